// File: rtl/level_req_queue.sv
// level_req_queue: per-level pending counters feeding an external priority
// encoder, plus a single-entry issue register toward the level logic.
// Upstream offers are counted per heap level; the encoder picks a level from
// pend and the chosen operation is moved into the issue register.
module level_req_queue #(
    parameter int unsigned LEVELS = 4,
    parameter int unsigned CNT_W  = 4,
    localparam int unsigned LW    = $clog2(LEVELS) + 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req_valid,
    input  logic [LW-1:0] req_level,
    output logic          req_ready,

    output logic [LEVELS:0] pend,
    input  logic [LW-1:0] sel,
    input  logic          sel_idle,

    output logic          iss_valid,
    output logic [LW-1:0] iss_level,
    input  logic          iss_ready,

    output logic          err
);

    localparam logic [LW-1:0]    MaxLevel = LW'(LEVELS);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [LEVELS+1];
    logic [CNT_W-1:0] cnt_d [LEVELS+1];

    logic          iss_valid_q, iss_valid_d;
    logic [LW-1:0] iss_level_q, iss_level_d;
    logic          err_q, err_d;

    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] sel_cnt;
    logic             req_in_range;
    logic             sel_in_range;
    logic             accept;
    logic             issue_free;
    logic             try_load;
    logic             load;

    // Counter lookup for the offered level and the encoder-selected level.
    // Done as an explicit mux so out-of-range indices read as zero.
    always_comb begin
        req_cnt = '0;
        sel_cnt = '0;
        pend    = '0;
        for (int i = 0; i <= int'(LEVELS); i++) begin
            if (req_level == LW'(i)) begin
                req_cnt = cnt_q[i];
            end
            if (sel == LW'(i)) begin
                sel_cnt = cnt_q[i];
            end
            pend[i] = (cnt_q[i] != '0);
        end
    end

    // Handshake decode: accept from upstream, load into the issue register.
    always_comb begin
        req_in_range = (req_level <= MaxLevel);
        sel_in_range = (sel <= MaxLevel);
        // Out-of-range offers are always taken (and flagged) so upstream never stalls.
        req_ready    = !req_in_range || (req_cnt != CntMax);
        accept       = req_valid && req_ready;
        issue_free   = !iss_valid_q || iss_ready;
        try_load     = !sel_idle && issue_free;
        load         = try_load && sel_in_range && (sel_cnt != '0);
    end

    // Counter next state: increment on accept, decrement on load; both cancel.
    always_comb begin
        for (int i = 0; i <= int'(LEVELS); i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && req_in_range && (req_level == LW'(i))) begin
                if (!(load && (sel == LW'(i)))) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (load && (sel == LW'(i))) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // Issue register and sticky error next state.
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_level_d = iss_level_q;
        err_d       = err_q;
        if (load) begin
            iss_valid_d = 1'b1;
            iss_level_d = sel;
        end else if (iss_valid_q && iss_ready) begin
            iss_valid_d = 1'b0;
        end
        // Bad offer level, or encoder pointing at an empty/invalid level.
        if ((accept && !req_in_range) || (try_load && !load)) begin
            err_d = 1'b1;
        end
    end

    // State registers; reset clears everything without waiting for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(LEVELS); i++) begin
                cnt_q[i] <= '0;
            end
            iss_valid_q <= 1'b0;
            iss_level_q <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i <= int'(LEVELS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            iss_valid_q <= iss_valid_d;
            iss_level_q <= iss_level_d;
            err_q       <= err_d;
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_level = iss_level_q;
    assign err       = err_q;

endmodule

// File: tb/tb_level_req_queue.sv
// tb_level_req_queue: directed bench for level_req_queue with a
// highest-index-wins priority encoder modelled in the bench.
module tb_level_req_queue;

    localparam int LEVELS = 4;
    localparam int LW     = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [LW-1:0] req_level;
    logic          req_ready;
    logic [LEVELS:0] pend;
    logic [LW-1:0] sel;
    logic          sel_idle;
    logic          iss_valid;
    logic [LW-1:0] iss_level;
    logic          iss_ready;
    logic          err;

    logic          ovr;
    logic          ovr_idle;
    logic [LW-1:0] ovr_sel;

    int n_chk = 0;
    int n_err = 0;

    level_req_queue #(.LEVELS(LEVELS), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_level (req_level),
        .req_ready (req_ready),
        .pend      (pend),
        .sel       (sel),
        .sel_idle  (sel_idle),
        .iss_valid (iss_valid),
        .iss_level (iss_level),
        .iss_ready (iss_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Priority encoder model: highest pending index wins; can be overridden.
    always_comb begin
        sel      = '0;
        sel_idle = 1'b1;
        for (int i = 0; i <= LEVELS; i++) begin
            if (pend[i]) begin
                sel      = 3'(i);
                sel_idle = 1'b0;
            end
        end
        if (ovr) begin
            sel      = ovr_sel;
            sel_idle = ovr_idle;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_level = '0;
        iss_ready = 1'b0;
        ovr       = 1'b0;
        @(negedge clk);
        check_eq("rst_pend", 32'(pend), 32'h0);
        check_eq("rst_iss_valid", 32'(iss_valid), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        check_eq("rst_req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts issues delivered with iss_ready held high until the queue drains.
    task automatic drain(output int n);
        n         = 0;
        req_valid = 1'b0;
        iss_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (iss_valid) n++;
            step();
        end
    endtask

    initial begin
        int n;
        ovr_idle = 1'b1;
        ovr_sel  = '0;

        // Single accept: pend after one edge, issue after two.
        do_reset();
        check_eq("rst_iss_level", 32'(iss_level), 32'h0);
        req_valid = 1'b1; req_level = 3'd2; iss_ready = 1'b1;
        step();
        check_eq("t1_pend", 32'(pend), 32'b00100);
        check_eq("t1_iss_v0", 32'(iss_valid), 32'h0);
        req_valid = 1'b0;
        step();
        check_eq("t1_iss_v1", 32'(iss_valid), 32'h1);
        check_eq("t1_iss_lvl", 32'(iss_level), 32'h2);
        check_eq("t1_pend0", 32'(pend), 32'h0);
        step();
        check_eq("t1_iss_done", 32'(iss_valid), 32'h0);

        // Back-to-back accepts 0,3,3: level 0 loads before level 3 arrives.
        req_valid = 1'b1; req_level = 3'd0;
        step();
        check_eq("t2_pend_a", 32'(pend), 32'b00001);
        req_level = 3'd3;
        step();
        check_eq("t2_iss_a", 32'(iss_level), 32'h0);
        check_eq("t2_pend_b", 32'(pend), 32'b01000);
        step();
        check_eq("t2_iss_b", 32'(iss_level), 32'h3);
        check_eq("t2_pend_c", 32'(pend), 32'b01000);
        req_valid = 1'b0;
        step();
        check_eq("t2_iss_c", 32'(iss_level), 32'h3);
        check_eq("t2_iss_c_v", 32'(iss_valid), 32'h1);
        check_eq("t2_pend_d", 32'(pend), 32'h0);
        step();
        check_eq("t2_idle", 32'(iss_valid), 32'h0);

        // Fill level 1 to saturation with the issue stalled.
        do_reset();
        req_valid = 1'b1; req_level = 3'd1;
        step();
        check_eq("t3_pend", 32'(pend), 32'b00010);
        check_eq("t3_iss_v0", 32'(iss_valid), 32'h0);
        repeat (14) step();
        check_eq("t3_iss_v", 32'(iss_valid), 32'h1);
        check_eq("t3_iss_lvl", 32'(iss_level), 32'h1);
        check_eq("t3_ready14", 32'(req_ready), 32'h1);
        step();
        check_eq("t3_ready_full", 32'(req_ready), 32'h0);
        req_level = 3'd0;
        #1;
        check_eq("t3_ready_lvl0", 32'(req_ready), 32'h1);
        drain(n);
        check_eq("t3_drain", 32'(n), 32'd16);
        check_eq("t3_err", 32'(err), 32'h0);

        // Level 4 at max with simultaneous issue: no overflow, stays on level 4.
        do_reset();
        req_valid = 1'b1; req_level = 3'd4;
        repeat (16) step();
        check_eq("t4_ready_full", 32'(req_ready), 32'h0);
        check_eq("t4_iss_lvl", 32'(iss_level), 32'h4);
        iss_ready = 1'b1;
        step();
        check_eq("t4_ready_after", 32'(req_ready), 32'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("t4_steady_lvl", 32'(iss_level), 32'h4);
            check_eq("t4_steady_v", 32'(iss_valid), 32'h1);
            check_eq("t4_steady_pend", 32'(pend), 32'b10000);
        end
        drain(n);
        check_eq("t4_drain", 32'(n), 32'd15);
        check_eq("t4_err", 32'(err), 32'h0);

        // Out-of-range offer: taken, counters untouched, sticky error.
        req_valid = 1'b1; req_level = 3'd7;
        #1;
        check_eq("t5_ready", 32'(req_ready), 32'h1);
        step();
        check_eq("t5_err", 32'(err), 32'h1);
        check_eq("t5_pend", 32'(pend), 32'h0);
        check_eq("t5_iss_v", 32'(iss_valid), 32'h0);
        req_valid = 1'b0;
        repeat (3) step();
        check_eq("t5_err_sticky", 32'(err), 32'h1);

        // Encoder selects an empty level: load suppressed, error raised.
        do_reset();
        ovr = 1'b1; ovr_idle = 1'b0; ovr_sel = 3'd2; iss_ready = 1'b1;
        step();
        check_eq("t6_err", 32'(err), 32'h1);
        check_eq("t6_iss_v", 32'(iss_valid), 32'h0);
        ovr = 1'b0;

        // Asynchronous reset mid-cycle with pending work and a held issue.
        do_reset();
        req_valid = 1'b1; req_level = 3'd1;
        repeat (4) step();
        req_level = 3'd7;
        step();
        check_eq("t7_pend", 32'(pend), 32'b00010);
        check_eq("t7_iss_v", 32'(iss_valid), 32'h1);
        check_eq("t7_err", 32'(err), 32'h1);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t7_rst_iss_v", 32'(iss_valid), 32'h0);
        check_eq("t7_rst_pend", 32'(pend), 32'h0);
        check_eq("t7_rst_err", 32'(err), 32'h0);
        check_eq("t7_rst_lvl", 32'(iss_level), 32'h0);
        #2;
        rst_n = 1'b1;
        req_valid = 1'b1; req_level = 3'd2;
        step();
        check_eq("t7_first_accept", 32'(pend), 32'b00100);
        req_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
